// File: rtl/seq_gen.sv
`default_nettype none
// ============================================================================
// Module  : seq_gen
// Brief   : Serial pattern transmitter. Sends PATTERN MSB-first, repeated
//           repeat_n times, with optional idle gap between frames.
// Rev     : 1.0 - initial release
// ============================================================================
module seq_gen #(
    parameter int               PAT_W   = 7,
    parameter logic [PAT_W-1:0] PATTERN = 7'b1110010,
    parameter int               CNT_W   = 4,
    parameter int               GAP_CYC = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] repeat_n,
    input  logic             en,
    input  logic             abort,
    output logic             dout,
    output logic             dout_vld,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    localparam int c_idx_w = $clog2(PAT_W);
    localparam int c_gap_w = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [c_idx_w-1:0] c_idx_top  = c_idx_w'(PAT_W - 1);
    localparam logic [c_gap_w-1:0] c_gap_load = (GAP_CYC > 0) ? c_gap_w'(GAP_CYC - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [c_idx_w-1:0] r_idx,   w_idx_nxt;
    logic [CNT_W-1:0]   r_frm,   w_frm_nxt;
    logic [c_gap_w-1:0] r_gap,   w_gap_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_idx   <= c_idx_top;
            r_frm   <= '0;
            r_gap   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_frm   <= w_frm_nxt;
            r_gap   <= w_gap_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_frm_nxt   = r_frm;
        w_gap_nxt   = r_gap;
        // Abort outranks both the bit strobe and burst completion
        if (abort && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = c_idx_top;
            w_frm_nxt   = '0;
            w_gap_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && (repeat_n != '0)) begin
                        w_state_nxt = S_SEND;
                        w_frm_nxt   = repeat_n;
                        w_idx_nxt   = c_idx_top;
                    end
                end
                S_SEND: begin
                    if (en) begin
                        if (r_idx != '0) begin
                            w_idx_nxt = r_idx - 1'b1;
                        end else begin
                            w_idx_nxt = c_idx_top;
                            w_frm_nxt = r_frm - 1'b1;
                            if (r_frm == CNT_W'(1)) begin
                                w_state_nxt = S_DONE;
                            end else if (GAP_CYC > 0) begin
                                w_state_nxt = S_GAP;
                                w_gap_nxt   = c_gap_load;
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (en) begin
                        if (r_gap == '0) begin
                            w_state_nxt = S_SEND;
                        end else begin
                            w_gap_nxt = r_gap - 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    w_state_nxt = S_IDLE;
                    w_idx_nxt   = c_idx_top;
                    w_frm_nxt   = '0;
                    w_gap_nxt   = '0;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_idx_nxt   = c_idx_top;
                    w_frm_nxt   = '0;
                    w_gap_nxt   = '0;
                end
            endcase
        end
    end

    // Moore decode; dout_vld alone follows the live strobe
    assign dout     = (r_state == S_SEND) ? PATTERN[r_idx] : 1'b0;
    assign dout_vld = (r_state == S_SEND) && en;
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_seq_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_seq_gen
// Brief   : Self-checking bench for seq_gen against a slot-queue model.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_seq_gen;

    localparam int c_pw  = 7;
    localparam int c_gap = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] repeat_n;
    logic       en;
    logic       abort;
    wire        dout;
    wire        dout_vld;
    wire        busy;
    wire        done;
    wire  [1:0] state;

    seq_gen #(
        .PAT_W   (7),
        .PATTERN (7'b1110010),
        .CNT_W   (4),
        .GAP_CYC (2)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .repeat_n (repeat_n),
        .en       (en),
        .abort    (abort),
        .dout     (dout),
        .dout_vld (dout_vld),
        .busy     (busy),
        .done     (done),
        .state    (state)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [6:0] pat_v  = 7'b1110010;

    // Model: a burst is a queue of slots (0/1 = data bit, 2 = idle slot),
    // each consumed by one strobe; phase 0 idle, 1 running, 3 done cycle.
    int q[$];
    int m_phase = 0;

    function automatic logic [5:0] model_out(input logic en_i);
        logic [5:0] r;
        logic       b;
        r = '0;
        if (m_phase == 1) begin
            if (q[0] < 2) begin
                b = (q[0] == 1);
                r = {2'd1, 1'b1, 1'b0, en_i, b};
            end else begin
                r = {2'd2, 1'b1, 3'b000};
            end
        end else if (m_phase == 3) begin
            r = {2'd3, 1'b1, 1'b1, 2'b00};
        end
        return r;
    endfunction

    task automatic model_edge();
        case (m_phase)
            0: if (start && (repeat_n != 4'd0)) begin
                for (int f = 0; f < int'(repeat_n); f++) begin
                    for (int b = c_pw - 1; b >= 0; b--) q.push_back(int'(pat_v[b]));
                    if (f < int'(repeat_n) - 1)
                        for (int g = 0; g < c_gap; g++) q.push_back(2);
                end
                m_phase = 1;
            end
            1: if (abort) begin
                q.delete();
                m_phase = 0;
            end else if (en) begin
                void'(q.pop_front());
                if (q.size() == 0) m_phase = 3;
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Loopback 1110010 detector fed on transferred bits
    logic [6:0] det_sr   = '0;
    int         det_hits = 0;
    always @(posedge clk) begin
        if (dout_vld) begin
            det_sr <= {det_sr[5:0], dout};
            if ({det_sr[5:0], dout} == 7'b1110010) det_hits <= det_hits + 1;
        end
    end

    logic [5:0] obs, exp_v;
    assign obs = {state, busy, done, dout_vld, dout};

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; repeat_n = '0; en = 1'b0; abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== 6'd0) begin
                errors++;
                $display("FAIL reset cyc%0d: got %b expected %b", i, obs, 6'd0);
            end
        end
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_single();
        int         done_at = -1;
        logic [6:0] got     = '0;
        for (int i = 0; i < 12; i++) begin
            start = (i == 0); repeat_n = 4'd1; en = 1'b1;
            @(negedge clk);
            exp_v = model_out(en);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL single cyc%0d: got %b expected %b", i, obs, exp_v);
            end
            if (dout_vld) got = {got[5:0], dout};
            if (done && done_at < 0) done_at = i;
            tick();
        end
        start = 1'b0;
        checks++;
        if (got !== 7'b1110010) begin
            errors++;
            $display("FAIL single_bits: got %b expected %b", got, 7'b1110010);
        end
        checks++;
        if (done_at != 8) begin
            errors++;
            $display("FAIL single_done_cycle: got %0d expected 8", done_at);
        end
    endtask

    task automatic test_gap();
        int done_at = -1;
        for (int i = 0; i < 30; i++) begin
            start = (i == 0); repeat_n = 4'd3; en = 1'b1;
            @(negedge clk);
            exp_v = model_out(en);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL gap cyc%0d: got %b expected %b", i, obs, exp_v);
            end
            if (done && done_at < 0) done_at = i;
            tick();
        end
        start = 1'b0;
        checks++;
        if (done_at != 26) begin
            errors++;
            $display("FAIL gap_done_cycle: got %0d expected 26", done_at);
        end
    endtask

    task automatic test_strobe();
        int         hits0 = det_hits;
        int         nvld  = 0;
        logic [6:0] got   = '0;
        for (int i = 0; i < 30; i++) begin
            start = (i == 0); repeat_n = 4'd1; en = ((i % 3) == 2);
            @(negedge clk);
            exp_v = model_out(en);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL strobe cyc%0d: got %b expected %b", i, obs, exp_v);
            end
            if (dout_vld) begin
                nvld++;
                got = {got[5:0], dout};
            end
            tick();
        end
        start = 1'b0; en = 1'b1;
        checks++;
        if (nvld != 7 || got !== 7'b1110010) begin
            errors++;
            $display("FAIL strobe_bits: got %0d bits %b expected 7 bits 1110010", nvld, got);
        end
        checks++;
        if (det_hits - hits0 != 1) begin
            errors++;
            $display("FAIL loopback_detect: got %0d hits expected 1", det_hits - hits0);
        end
    endtask

    task automatic test_ignore();
        int done_at = -1;
        int nbusy   = 0;
        for (int i = 0; i < 5; i++) begin
            start = 1'b1; repeat_n = 4'd0; en = 1'b1;
            @(negedge clk);
            exp_v = model_out(en);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL ignore_zero cyc%0d: got %b expected %b", i, obs, exp_v);
            end
            if (busy || done) nbusy++;
            tick();
        end
        checks++;
        if (nbusy != 0) begin
            errors++;
            $display("FAIL ignore_zero_busy: got %0d busy cycles expected 0", nbusy);
        end
        for (int i = 0; i < 20; i++) begin
            start = (i == 0) || (i >= 3 && i < 6);
            repeat_n = (i == 0) ? 4'd2 : 4'd5;
            en = 1'b1;
            @(negedge clk);
            exp_v = model_out(en);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL ignore_mid cyc%0d: got %b expected %b", i, obs, exp_v);
            end
            if (done && done_at < 0) done_at = i;
            tick();
        end
        start = 1'b0;
        checks++;
        if (done_at != 17) begin
            errors++;
            $display("FAIL ignore_mid_done_cycle: got %0d expected 17", done_at);
        end
    endtask

    task automatic test_abort();
        int ndone   = 0;
        int done_at = -1;
        for (int i = 0; i < 30; i++) begin
            start = (i == 0); repeat_n = 4'd3; en = 1'b1; abort = (i == 13);
            @(negedge clk);
            exp_v = model_out(en);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL abort cyc%0d: got %b expected %b", i, obs, exp_v);
            end
            if (i == 14) begin
                checks++;
                if (state !== 2'd0 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_idle: got state %0d busy %b expected 0 0", state, busy);
                end
            end
            if (done) ndone++;
            tick();
        end
        abort = 1'b0;
        checks++;
        if (ndone != 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d done pulses expected 0", ndone);
        end
        for (int i = 0; i < 12; i++) begin
            start = (i == 0); repeat_n = 4'd1; en = 1'b1;
            @(negedge clk);
            exp_v = model_out(en);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL abort_restart cyc%0d: got %b expected %b", i, obs, exp_v);
            end
            if (done && done_at < 0) done_at = i;
            tick();
        end
        start = 1'b0;
        checks++;
        if (done_at != 8) begin
            errors++;
            $display("FAIL abort_restart_done: got %0d expected 8", done_at);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 9; i++) begin
            start = (i == 0); repeat_n = 4'd2; en = 1'b1;
            @(negedge clk);
            exp_v = model_out(en);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL areset_pre cyc%0d: got %b expected %b", i, obs, exp_v);
            end
            if (i < 8) tick();
        end
        start = 1'b0;
        checks++;
        if (state !== 2'd2) begin
            errors++;
            $display("FAIL areset_in_gap: got state %0d expected 2", state);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (obs !== 6'd0) begin
            errors++;
            $display("FAIL areset_immediate: got %b expected %b", obs, 6'd0);
        end
        q.delete();
        m_phase = 0;
        @(posedge clk); #1;
        reset = 1'b1;
        test_single();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            start    = ($urandom_range(0, 9) == 0);
            repeat_n = 4'($urandom_range(0, 3));
            en       = ($urandom_range(0, 9) < 7);
            abort    = ($urandom_range(0, 49) == 0);
            @(negedge clk);
            exp_v = model_out(en);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL random cyc%0d: got %b expected %b", i, obs, exp_v);
            end
            tick();
        end
        start = 1'b0; abort = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_gap();
        test_strobe();
        test_ignore();
        test_abort();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
